lfsr_rng_gen: RTL and testbench



---
 rtl/lfsr_pkg.sv | 15 +
 rtl/lfsr_core.sv | 42 ++++
 rtl/lfsr_rng_gen.sv | 153 +++++++++++++++
 tb/tb_lfsr_rng_gen.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR random generator.
// Tap masks give maximal-length sequences for common widths.
package lfsr_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } fsm_state_e;

  localparam logic [3:0]  TAPS_W4  = 4'hC;
  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [15:0] TAPS_W16 = 16'hB400;
  localparam logic [31:0] TAPS_W32 = 32'h80200003;

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR register with feedback XOR, load mux and zero detect.
// A load takes precedence over a step in the same cycle.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = TAPS_W16,
  parameter logic [WIDTH-1:0] SEED  = 16'hACE1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] state,
  output logic             zero
);

  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = load_val;
    end else if (step) begin
      lfsr_d = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state = lfsr_q;
  assign zero  = (lfsr_q == '0);

endmodule

// File: rtl/lfsr_rng_gen.sv
// Random sample generator: LFSR shifted STEPS times per OUT_W-bit sample,
// delivered over valid/ready, with reseeding and all-zero lockup recovery.
module lfsr_rng_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = TAPS_W16,
  parameter logic [WIDTH-1:0] SEED  = 16'hACE1,
  parameter int unsigned      OUT_W = 4,
  parameter int unsigned      STEPS = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             rnd_ready,
  output logic             rnd_valid,
  output logic [OUT_W-1:0] rnd,
  output logic             lockup
);

  localparam int unsigned      CNT_W = $clog2(STEPS + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(STEPS - 1);

  if (WIDTH < 3 || WIDTH > 32) begin : g_err_width
    $error("lfsr_rng_gen: WIDTH must be in 3..32");
  end
  if (SEED == '0) begin : g_err_seed
    $error("lfsr_rng_gen: SEED must be non-zero");
  end
  if (TAPS[WIDTH-1] == 1'b0) begin : g_err_taps
    $error("lfsr_rng_gen: TAPS[WIDTH-1] must be set");
  end
  if (OUT_W < 1 || OUT_W > WIDTH) begin : g_err_out_w
    $error("lfsr_rng_gen: OUT_W must be in 1..WIDTH");
  end
  if (STEPS < 1) begin : g_err_steps
    $error("lfsr_rng_gen: STEPS must be at least 1");
  end

  logic [WIDTH-1:0] lfsr_state;
  logic             lfsr_zero;
  logic             core_step;
  logic             core_load;
  logic [WIDTH-1:0] core_load_val;

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_core (
    .clock    (clock),
    .reset    (reset),
    .step     (core_step),
    .load     (core_load),
    .load_val (core_load_val),
    .state    (lfsr_state),
    .zero     (lfsr_zero)
  );

  // Low bits of the post-shift value, i.e. what the LFSR will hold after this edge.
  logic             fb;
  logic [OUT_W-1:0] sample_next;

  assign fb = ^(lfsr_state & TAPS);

  if (OUT_W == 1) begin : g_sample_1
    assign sample_next = fb;
  end else begin : g_sample_n
    assign sample_next = {lfsr_state[OUT_W-2:0], fb};
  end

  fsm_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [OUT_W-1:0] rnd_q, rnd_d;
  logic             rnd_valid_q, rnd_valid_d;
  logic             lockup_q, lockup_d;

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    rnd_d         = rnd_q;
    rnd_valid_d   = rnd_valid_q;
    lockup_d      = 1'b0;
    core_step     = 1'b0;
    core_load     = 1'b0;
    core_load_val = seed_in;

    if (seed_load) begin
      core_load   = 1'b1;
      count_d     = '0;
      state_d     = FILL;
      rnd_valid_d = 1'b0;
      if (seed_in == '0) begin
        core_load_val = SEED;
        lockup_d      = 1'b1;
      end
    end else begin
      // Recovery replaces the shift for this cycle, so the count does not advance.
      if (lfsr_zero) begin
        core_load     = 1'b1;
        core_load_val = SEED;
        lockup_d      = 1'b1;
      end else begin
        core_step = enable;
      end

      case (state_q)
        FILL: begin
          if (core_step) begin
            if (count_q == LAST) begin
              rnd_d       = sample_next;
              rnd_valid_d = 1'b1;
              count_d     = '0;
              state_d     = HOLD;
            end else begin
              count_d = count_q + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (rnd_valid_q && rnd_ready) begin
            rnd_valid_d = 1'b0;
            state_d     = FILL;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= FILL;
      count_q     <= '0;
      rnd_q       <= '0;
      rnd_valid_q <= 1'b0;
      lockup_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rnd_q       <= rnd_d;
      rnd_valid_q <= rnd_valid_d;
      lockup_q    <= lockup_d;
    end
  end

  assign rnd       = rnd_q;
  assign rnd_valid = rnd_valid_q;
  assign lockup    = lockup_q;

endmodule

// File: tb/tb_lfsr_rng_gen.sv
// Self-checking bench: a 4-bit STEPS=1 instance driven from a vector table and
// a default-parameter instance checked against a reference LFSR and sample queue.
module tb_lfsr_rng_gen;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;

  logic       a_en, a_sl, a_rdy, a_valid, a_lock;
  logic [3:0] a_seed, a_rnd;

  logic        b_en, b_sl, b_rdy, b_valid, b_lock;
  logic [15:0] b_seed;
  logic [3:0]  b_rnd;

  lfsr_rng_gen #(
    .WIDTH (4),
    .TAPS  (4'hC),
    .SEED  (4'd13),
    .OUT_W (4),
    .STEPS (1)
  ) u_a (
    .clock     (clock),
    .reset     (reset),
    .enable    (a_en),
    .seed_load (a_sl),
    .seed_in   (a_seed),
    .rnd_ready (a_rdy),
    .rnd_valid (a_valid),
    .rnd       (a_rnd),
    .lockup    (a_lock)
  );

  lfsr_rng_gen u_b (
    .clock     (clock),
    .reset     (reset),
    .enable    (b_en),
    .seed_load (b_sl),
    .seed_in   (b_seed),
    .rnd_ready (b_rdy),
    .rnd_valid (b_valid),
    .rnd       (b_rnd),
    .lockup    (b_lock)
  );

  typedef struct packed {
    logic       en;
    logic       rdy;
    logic [3:0] lfsr;
    logic       v;
    logic [3:0] rnd;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] m_lfsr;
  logic [3:0]  exp_q[$];
  vec_t        a_q[$];
  logic        b_valid_prev;
  logic [3:0]  last_rnd;

  function automatic logic [15:0] step16(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock of instance B: drive, advance the reference, compare after the edge.
  task automatic b_cycle(input logic en, input logic rdy, input logic sl,
                         input logic [15:0] sd, input logic exp_v, input logic exp_lock);
    logic [3:0] want;
    b_en   = en;
    b_rdy  = rdy;
    b_sl   = sl;
    b_seed = sd;
    if (sl) m_lfsr = (sd == 16'h0) ? 16'hACE1 : sd;
    else if (m_lfsr == 16'h0) m_lfsr = 16'hACE1;
    else if (en) m_lfsr = step16(m_lfsr);
    if (exp_v && !b_valid_prev) exp_q.push_back(m_lfsr[3:0]);
    @(posedge clock);
    @(negedge clock);
    check("b_lfsr", u_b.u_core.lfsr_q, m_lfsr);
    check("b_valid", b_valid, exp_v);
    check("b_lockup", b_lock, exp_lock);
    if (b_valid && !b_valid_prev) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL b_sample: got %0h, expected no sample", b_rnd);
      end else begin
        want = exp_q.pop_front();
        check("b_sample", b_rnd, want);
        last_rnd = want;
      end
    end else if (b_valid && b_valid_prev) begin
      check("b_rnd_stable", b_rnd, last_rnd);
    end
    b_valid_prev = b_valid;
    b_sl = 1'b0;
    $display("[TB] B en=%0d rdy=%0d load=%0d seed=%h lfsr=%h valid=%0d rnd=%h lockup=%0d",
             en, rdy, sl, sd, u_b.u_core.lfsr_q, b_valid, b_rnd, b_lock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset        = 1'b0;
    m_lfsr       = 16'hACE1;
    b_valid_prev = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    vec_t vecs[10];
    vec_t e;
    int   first_ret, zero_seen, lock_seen, mism;

    vecs[0] = '{en: 1'b1, rdy: 1'b1, lfsr: 4'd10, v: 1'b1, rnd: 4'd10};
    vecs[1] = '{en: 1'b1, rdy: 1'b1, lfsr: 4'd5,  v: 1'b0, rnd: 4'd10};
    vecs[2] = '{en: 1'b0, rdy: 1'b1, lfsr: 4'd5,  v: 1'b0, rnd: 4'd10};
    vecs[3] = '{en: 1'b1, rdy: 1'b0, lfsr: 4'd11, v: 1'b1, rnd: 4'd11};
    vecs[4] = '{en: 1'b0, rdy: 1'b0, lfsr: 4'd11, v: 1'b1, rnd: 4'd11};
    vecs[5] = '{en: 1'b1, rdy: 1'b0, lfsr: 4'd7,  v: 1'b1, rnd: 4'd11};
    vecs[6] = '{en: 1'b0, rdy: 1'b1, lfsr: 4'd7,  v: 1'b0, rnd: 4'd11};
    vecs[7] = '{en: 1'b1, rdy: 1'b1, lfsr: 4'd15, v: 1'b1, rnd: 4'd15};
    vecs[8] = '{en: 1'b1, rdy: 1'b1, lfsr: 4'd14, v: 1'b0, rnd: 4'd15};
    vecs[9] = '{en: 1'b1, rdy: 1'b1, lfsr: 4'd12, v: 1'b1, rnd: 4'd12};

    reset  = 1'b1;
    a_en   = 1'b0; a_sl = 1'b0; a_rdy = 1'b0; a_seed = 4'h0;
    b_en   = 1'b0; b_sl = 1'b0; b_rdy = 1'b0; b_seed = 16'h0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset        = 1'b0;
    m_lfsr       = 16'hACE1;
    b_valid_prev = 1'b0;
    last_rnd     = 4'h0;

    check("a_reset_lfsr", u_a.u_core.lfsr_q, 4'd13);
    check("a_reset_valid", a_valid, 1'b0);
    check("a_reset_rnd", a_rnd, 4'h0);
    check("a_reset_lockup", a_lock, 1'b0);
    check("b_reset_lfsr", u_b.u_core.lfsr_q, 16'hACE1);
    check("b_reset_valid", b_valid, 1'b0);
    check("b_reset_rnd", b_rnd, 4'h0);

    // Small instance, one sample per shift, table of enable/ready patterns.
    for (int i = 0; i < 10; i++) begin
      a_en  = vecs[i].en;
      a_rdy = vecs[i].rdy;
      a_q.push_back(vecs[i]);
      @(posedge clock);
      @(negedge clock);
      e = a_q.pop_front();
      check("a_lfsr", u_a.u_core.lfsr_q, e.lfsr);
      check("a_valid", a_valid, e.v);
      check("a_rnd", a_rnd, e.rnd);
      check("a_lockup", a_lock, 1'b0);
      $display("[TB] A row %0d en=%0d rdy=%0d lfsr=%0d valid=%0d rnd=%0d",
               i, e.en, e.rdy, u_a.u_core.lfsr_q, a_valid, a_rnd);
    end
    a_en  = 1'b0;
    a_rdy = 1'b0;

    // First sample after STEPS edges, then back-pressure for 20 cycles.
    for (int i = 1; i <= 8; i++) b_cycle(1'b1, 1'b0, 1'b0, 16'h0, i == 8, 1'b0);
    for (int i = 0; i < 20; i++) b_cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    b_cycle(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) b_cycle(1'b1, 1'b0, 1'b0, 16'h0, i == 8, 1'b0);

    // Reseed mid-fill restarts the count; a zero seed falls back to SEED.
    b_cycle(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) b_cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    b_cycle(1'b1, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) b_cycle(1'b1, 1'b0, 1'b0, 16'h0, i == 8, 1'b0);
    b_cycle(1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1);
    b_cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);

    // Upset to all-zero: recovery cycle does not count as a shift.
    force u_b.u_core.lfsr_q = 16'h0000;
    #1;
    release u_b.u_core.lfsr_q;
    m_lfsr = 16'h0000;
    check("b_forced_zero", u_b.u_core.lfsr_q, 16'h0000);
    b_cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    for (int i = 1; i <= 7; i++) b_cycle(1'b1, 1'b0, 1'b0, 16'h0, i == 7, 1'b0);
    b_cycle(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);

    // Full period of the default 16-bit LFSR.
    do_reset();
    b_en      = 1'b1;
    b_rdy     = 1'b1;
    first_ret = 0;
    zero_seen = 0;
    lock_seen = 0;
    mism      = 0;
    for (int i = 1; i <= 65535; i++) begin
      @(posedge clock);
      @(negedge clock);
      m_lfsr = step16(m_lfsr);
      if (u_b.u_core.lfsr_q !== m_lfsr) mism++;
      if (u_b.u_core.lfsr_q == 16'h0) zero_seen++;
      if (b_lock) lock_seen++;
      if (u_b.u_core.lfsr_q == 16'hACE1 && first_ret == 0) first_ret = i;
    end
    check("period_length", first_ret, 65535);
    check("period_zero_states", zero_seen, 0);
    check("period_lockups", lock_seen, 0);
    check("period_model_mismatches", mism, 0);
    $display("[TB] B period return after %0d shifts", first_ret);

    // Alternating enable: eight enabled edges out of fifteen, then reset while valid.
    do_reset();
    for (int i = 1; i <= 15; i++) b_cycle(i % 2 == 1, 1'b0, 1'b0, 16'h0, i == 15, 1'b0);
    b_en  = 1'b1;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("b_rst_valid", b_valid, 1'b0);
    check("b_rst_rnd", b_rnd, 4'h0);
    check("b_rst_lfsr", u_b.u_core.lfsr_q, 16'hACE1);
    check("b_rst_lockup", b_lock, 1'b0);
    reset = 1'b0;
    b_en  = 1'b0;

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
